// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: PWM driver for NUM_LEDS tri-colour LEDs.
//   - one shared prescaler / PWM counter / blink phase / breathe ramp
//   - one pending configuration slot, committed at a PWM period wrap
//   - per-LED duty registers and comparators in rgb_led_pwm_chan
// Optional feature: define RGB_LED_PWM_BREATHE_EN to build the breathe ramp.
// Without it, mode 11 (breathe) behaves exactly like steady.

// Per-LED channel: holds the active duties/mode for one RGB LED and
// produces its three registered PWM outputs.
module rgb_led_pwm_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] r,
    input  logic [W-1:0] g,
    input  logic [W-1:0] b,
    input  logic [1:0]   mode,
    input  logic [W-1:0] pwm_cnt,
    input  logic         blink_on,
`ifdef RGB_LED_PWM_BREATHE_EN
    input  logic [W-1:0] ramp,
`endif
    output logic [2:0]   rgb
);

    // index 0 = R, 1 = G, 2 = B (matches the bit order on the rgb bus)
    logic [2:0][W-1:0] duty_q;
    logic [2:0][W-1:0] duty_eff;
    logic [1:0]        mode_q;

`ifdef RGB_LED_PWM_BREATHE_EN
    // Full 2W-bit product; the upper W bits give duty*ramp/2^W, truncated.
    logic [2:0][2*W-1:0] prod;
    for (genvar c = 0; c < 3; c++) begin : g_prod
        assign prod[c] = {{W{1'b0}}, duty_q[c]} * {{W{1'b0}}, ramp};
    end
`endif

    // Active configuration; only written on a commit (period boundary).
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            mode_q <= 2'b00;
        end else if (we) begin
            duty_q <= {b, g, r};
            mode_q <= mode;
        end
    end

    // Effective duty per colour from the mode and the shared phase signals.
    always_comb begin
        duty_eff = '0;
        for (int c = 0; c < 3; c++) begin
            case (mode_q)
                2'b01:   duty_eff[c] = duty_q[c];
                2'b10:   duty_eff[c] = blink_on ? duty_q[c] : '0;
`ifdef RGB_LED_PWM_BREATHE_EN
                2'b11:   duty_eff[c] = prod[c][2*W-1:W];
`else
                2'b11:   duty_eff[c] = duty_q[c];
`endif
                default: duty_eff[c] = '0;
            endcase
        end
    end

    // Registered comparator: output lags pwm_cnt by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= 3'b000;
        end else begin
            for (int c = 0; c < 3; c++) begin
                rgb[c] <= (pwm_cnt < duty_eff[c]);
            end
        end
    end

endmodule

// Top level: shared timing, configuration slot and the per-LED channels.
module rgb_led_pwm #(
    parameter int NUM_LEDS      = 2,
    parameter int PWM_WIDTH     = 8,
    parameter int PRESCALE      = 1000,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              cfg_valid,
    output logic                                              cfg_ready,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_led,
    input  logic [PWM_WIDTH-1:0]                              cfg_r,
    input  logic [PWM_WIDTH-1:0]                              cfg_g,
    input  logic [PWM_WIDTH-1:0]                              cfg_b,
    input  logic [1:0]                                        cfg_mode,
    output logic [3*NUM_LEDS-1:0]                             rgb,
    output logic                                              period_tick
);

    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

    typedef struct packed {
        logic [LED_W-1:0]     led;
        logic [PWM_WIDTH-1:0] r;
        logic [PWM_WIDTH-1:0] g;
        logic [PWM_WIDTH-1:0] b;
        logic [1:0]           mode;
    } cfg_t;

    logic [PRE_W-1:0]     pre_cnt;
    logic                 tick;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 wrap;
    logic [BLK_W-1:0]     blink_cnt;
    logic                 blink_on;
    cfg_t                 slot;
    logic                 pending;
    logic                 accept;
    logic                 commit;
    logic [NUM_LEDS-1:0][2:0] led_q;

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign wrap      = tick && (pwm_cnt == PWM_MAX);
    assign cfg_ready = !pending && !rst;
    assign accept    = cfg_valid && cfg_ready;
    // pending blocks cfg_ready, so accept and commit are never both true.
    assign commit    = wrap && pending;
    assign rgb       = led_q;

    // Prescaler: one PWM tick every PRESCALE clocks.
    always_ff @(posedge clk) begin
        if (rst || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    // PWM counter, free-running modulo 2^W in ticks.
    always_ff @(posedge clk) begin
        if (rst)       pwm_cnt <= '0;
        else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Period pulse, one cycle after the wrap it marks.
    always_ff @(posedge clk) begin
        if (rst) period_tick <= 1'b0;
        else     period_tick <= wrap;
    end

    // Single-entry configuration slot; drained at the next period wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            slot    <= '0;
        end else if (accept) begin
            pending <= 1'b1;
            slot    <= '{led: cfg_led, r: cfg_r, g: cfg_g, b: cfg_b, mode: cfg_mode};
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    // Shared blink phase: blink_on flips every BLINK_PERIODS periods and is
    // never disturbed by configuration writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (wrap) begin
            if (blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef RGB_LED_PWM_BREATHE_EN
    logic [PWM_WIDTH-1:0] ramp;
    logic                 ramp_up;

    // Triangle ramp, one step per period; each endpoint lasts one period.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (wrap) begin
            if (ramp_up) begin
                if (ramp == PWM_MAX) begin
                    ramp    <= ramp - 1'b1;
                    ramp_up <= 1'b0;
                end else begin
                    ramp <= ramp + 1'b1;
                end
            end else begin
                if (ramp == '0) begin
                    ramp    <= ramp + 1'b1;
                    ramp_up <= 1'b1;
                end else begin
                    ramp <= ramp - 1'b1;
                end
            end
        end
    end
`endif

    // Per-LED channels; an out-of-range slot.led matches no channel and the
    // committed entry is simply dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        rgb_led_pwm_chan #(.W(PWM_WIDTH)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .we       (commit && (slot.led == LED_W'(i))),
            .r        (slot.r),
            .g        (slot.g),
            .b        (slot.b),
            .mode     (slot.mode),
            .pwm_cnt  (pwm_cnt),
            .blink_on (blink_on),
`ifdef RGB_LED_PWM_BREATHE_EN
            .ramp     (ramp),
`endif
            .rgb      (led_q[i])
        );
    end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm: NUM_LEDS=3, W=4, PRESCALE=1,
// BLINK_PERIODS=2, so one PWM period is 16 clocks.
// After the second reset, cyc counts clock edges; edge c reflects pwm_cnt
// value (c-1)%16 of period (c-1)/16. Per-period on-counts of each rgb bit
// are accumulated in hist[][] and compared with hand-computed values.
module tb_rgb_led_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_led;
    logic [3:0] cfg_r, cfg_g, cfg_b;
    logic [1:0] cfg_mode;
    logic [8:0] rgb;
    logic       period_tick;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    bit track  = 1'b0;
    int hist [0:19][0:8];

`ifdef RGB_LED_PWM_BREATHE_EN
    localparam int BR15 = 14, BR16 = 13, BR17 = 12;
`else
    localparam int BR15 = 15, BR16 = 15, BR17 = 15;
`endif

    rgb_led_pwm #(
        .NUM_LEDS(3), .PWM_WIDTH(4), .PRESCALE(1), .BLINK_PERIODS(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_led(cfg_led), .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b),
        .cfg_mode(cfg_mode), .rgb(rgb), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step();
        int p;
        @(posedge clk);
        #1;
        if (track) begin
            cyc++;
            p = (cyc - 1) / 16;
            if (p < 20)
                for (int b = 0; b < 9; b++) hist[p][b] += int'(rgb[b]);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive(input logic [1:0] led, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic [1:0] mode);
        cfg_valid = 1'b1;
        cfg_led   = led;
        cfg_r     = r;
        cfg_g     = g;
        cfg_b     = b;
        cfg_mode  = mode;
    endtask

    initial begin
        int ones;
        for (int p = 0; p < 20; p++)
            for (int b = 0; b < 9; b++) hist[p][b] = 0;
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_led = '0; cfg_r = '0; cfg_g = '0; cfg_b = '0; cfg_mode = '0;
        repeat (2) step();
        rst = 1'b0;

        // Warm-up: LED0 steady R=8, then reset it mid-period.
        drive(2'd0, 4'd8, 4'd0, 4'd0, 2'b01);
        step();
        cfg_valid = 1'b0;
        chk("pre_ready_low", cfg_ready, 0);
        repeat (40) step();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            ones += int'(rgb[0]);
        end
        chk("pre_r8_count", ones, 8);
        repeat (5) step();

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rgb", rgb, 0);
            chk("rst_ready", cfg_ready, 0);
            chk("rst_ptick", period_tick, 0);
        end
        rst = 1'b0;
        #1;
        chk("rst_ready_after", cfg_ready, 1);
        track = 1'b1;
        cyc   = 0;

        // Duty: LED0 steady R=5 G=0 B=15, accepted at edge 1, commit at 16.
        drive(2'd0, 4'd5, 4'd0, 4'd15, 2'b01);
        step();
        cfg_valid = 1'b0;
        go(15); chk("ptick_c15", period_tick, 0);
        go(16); chk("ptick_c16", period_tick, 1);
        go(17); chk("ptick_c17", period_tick, 0);
        chk("rgb_c17", rgb, 9'b000_000_101);
        go(21); chk("r_pwm4", rgb[0], 1);
        go(22); chk("r_pwm5", rgb[0], 0);

        // Backpressure: LED1 G=3 then LED2 R=7 back to back.
        go(32);
        drive(2'd1, 4'd0, 4'd3, 4'd0, 2'b01);
        step();
        drive(2'd2, 4'd7, 4'd0, 4'd0, 2'b01);
        chk("bp_ready_c33", cfg_ready, 0);
        go(47); chk("bp_ready_c47", cfg_ready, 0);
        go(48); chk("bp_ready_c48", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("bp_ready_c49", cfg_ready, 0);

        // Blink: LED1 G=15, commit at edge 96.
        go(80);
        drive(2'd1, 4'd0, 4'd15, 4'd0, 2'b10);
        step();
        cfg_valid = 1'b0;

        // Out-of-range index 3: accepted, then dropped at commit.
        go(192);
        drive(2'd3, 4'd15, 4'd15, 4'd15, 2'b01);
        step();
        cfg_valid = 1'b0;
        chk("oor_ready_c193", cfg_ready, 0);
        go(208); chk("oor_ready_c208", cfg_ready, 1);

        // Breathe: LED2 B=15, commit at edge 240.
        go(224);
        drive(2'd2, 4'd0, 4'd0, 4'd15, 2'b11);
        step();
        cfg_valid = 1'b0;
        go(288);

        chk("p0_r", hist[0][0], 0);
        chk("p0_b", hist[0][2], 0);
        chk("p1_r", hist[1][0], 5);
        chk("p1_g", hist[1][1], 0);
        chk("p1_b", hist[1][2], 15);
        chk("p1_l1g", hist[1][4], 0);
        chk("p2_l1g", hist[2][4], 0);
        chk("p3_l1g", hist[3][4], 3);
        chk("p3_l2r", hist[3][6], 0);
        chk("p4_l1g", hist[4][4], 3);
        chk("p4_l2r", hist[4][6], 7);
        chk("p4_r", hist[4][0], 5);
        chk("p5_l1g", hist[5][4], 3);
        chk("p6_blink", hist[6][4], 0);
        chk("p7_blink", hist[7][4], 0);
        chk("p8_blink", hist[8][4], 15);
        chk("p9_blink", hist[9][4], 15);
        chk("p10_blink", hist[10][4], 0);
        chk("p11_blink", hist[11][4], 0);
        chk("p12_blink", hist[12][4], 15);
        chk("p13_oor_l0g", hist[13][1], 0);
        chk("p13_oor_l0r", hist[13][0], 5);
        chk("p13_oor_l1r", hist[13][3], 0);
        chk("p13_oor_l1g", hist[13][4], 15);
        chk("p13_oor_l2r", hist[13][6], 7);
        chk("p13_oor_l2g", hist[13][7], 0);
        chk("p14_l1g", hist[14][4], 0);
        chk("p14_l2b", hist[14][8], 0);
        chk("p15_l2r", hist[15][6], 0);
        chk("p15_breathe", hist[15][8], BR15);
        chk("p16_breathe", hist[16][8], BR16);
        chk("p17_breathe", hist[17][8], BR17);
        chk("p17_b", hist[17][2], 15);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/rgb_led_pwm.md
# rgb_led_pwm

Parametrised PWM driver for an array of tri-colour (RGB) LEDs, with per-LED 8-level-or-wider brightness per colour and per-LED steady/blink/breathe modes. Sits between the PS-side control logic (AXI GPIO or register block) and the board LED pins, replacing the static 6-bit `rgb` bus used on the PYNQ-Z2 HDMI-out top with a brightness-controlled one. Configuration is accepted through a valid/ready port and applied glitch-free at PWM period boundaries.

## Interface
- `NUM_LEDS`, 2: number of RGB LEDs; ≥1.
- `PWM_WIDTH`, 8: duty/counter width W; PWM period = 2^W ticks.
- `PRESCALE`, 1000: clk cycles per PWM tick; ≥1.
- `BLINK_PERIODS`, 64: PWM periods per blink half-cycle; ≥1.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_led` in max(1,$clog2(NUM_LEDS)): target LED index; indices ≥NUM_LEDS accepted and discarded.
- `cfg_r`, `cfg_g`, `cfg_b` in W each: duty per colour.
- `cfg_mode` in 2: 00 off, 01 steady, 10 blink, 11 breathe.
- `rgb` out 3*NUM_LEDS: LED i drives bit 3i=R, 3i+1=G, 3i+2=B; active-high.
- `period_tick` out 1: one-cycle pulse on each PWM period wrap.

## Operation
- Prescaler: counts 0..PRESCALE-1; `tick` asserted on PRESCALE-1, then wraps to 0.
- PWM counter `pwm_cnt` (W bits): increments on `tick`, wraps 2^W-1→0. Wrap event `wrap = tick && pwm_cnt==2^W-1`; `period_tick` = registered `wrap`.
- Pending slot: one entry {led, r, g, b, mode}. `cfg_ready = !pending && !rst`. Handshake loads slot, sets `pending`.
- Commit: on `wrap` with `pending`, slot copied to active registers of `cfg_led` (discarded if out of range), `pending` cleared. `cfg_ready` rises the cycle after commit; no write can coincide with commit.
- Blink phase: period counter 0..BLINK_PERIODS-1 advanced on `wrap`; `blink_on` toggles at its wrap. Shared by all LEDs.
- Effective duty per colour: off→0; steady→duty; blink→duty if `blink_on` else 0; breathe→see Configuration.
- Output: `rgb[bit] <= (pwm_cnt < duty_eff)`, registered. Duty 0 = always off; duty 2^W-1 = on 2^W-1 of 2^W ticks.
- Mode change to/from blink does not reset blink phase.

## Timing
- Reset (sync, `rst`=1 on a clk edge): `rgb`=0, `period_tick`=0, `cfg_ready`=0 while `rst` high, 1 on first cycle after; all active duties 0, modes off, pending cleared, prescaler/pwm/blink counters 0, `blink_on`=1, breathe ramp 0 rising.
- Reset mid-operation: pending write lost; outputs 0 on the edge after `rst` sampled high.
- Config latency: accepted at cycle A; committed at first `wrap` after A; new duty visible on `rgb` one cycle after `pwm_cnt` reaches 0 (register stage).
- `rgb` lags `pwm_cnt` by exactly 1 cycle; `period_tick` lags `wrap` by 1 cycle.
- PRESCALE=1: `tick` every cycle; period = 2^W cycles.

## Configuration
- `RGB_LED_PWM_BREATHE_EN` defined: global W-bit triangle ramp, stepping ±1 per `wrap`, 0→2^W-1→0 (reverses at ends, endpoints held one period each); breathe duty_eff = (duty × ramp) >> W (2W-bit product, upper W bits, truncation).
- Not defined: no ramp logic; mode 11 behaves as steady.

## Test plan
- Reset: hold `rst` 3 cycles mid-period with LED0 steady R=8 → `rgb`=0, `cfg_ready`=0 during reset, `cfg_ready`=1 next cycle, counters at 0.
- Duty (W=4, PRESCALE=1): LED0 steady R=5,G=0,B=15 → per 16-cycle period bit0 high 5 cycles, bit1 never, bit2 15 cycles; first change only after next `period_tick`.
- Backpressure: two back-to-back writes → second held with `cfg_ready`=0 until cycle after commit; both take effect on consecutive periods.
- Blink (BLINK_PERIODS=2): LED1 blink G=15 → bit4 active 2 periods, dark 2 periods, repeating.
- Out-of-range: NUM_LEDS=3, `cfg_led`=3 → handshake completes, no `rgb` change.
- Breathe (macro on, W=4): B=15 → duty_eff follows (15×ramp)>>4: 0,0,1,2…14,13…; macro off → constant 15.
